// File: rtl/approx_mult_pkg.sv
// ----------------------------------------------------------------------------
// approx_mult_pkg
// Shared definitions for the approximate shift-add multiplier:
//   - state_t      : controller states (IDLE, CALC, DONE)
//   - approx_sum / approx_cout : approximate full-adder cell (carry-in ignored)
//   - exact_sum  / exact_cout  : conventional full-adder cell
// ----------------------------------------------------------------------------
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Approximate cell: OR for the sum, AND for the carry, carry-in dropped.
    // Correct whenever at most one of x/y is set, which is the common case
    // for sparse low-order partial-product bits.
    function automatic logic approx_sum(input logic x, input logic y);
        return x | y;
    endfunction

    function automatic logic approx_cout(input logic x, input logic y);
        return x & y;
    endfunction

    function automatic logic exact_sum(input logic x, input logic y, input logic cin);
        return x ^ y ^ cin;
    endfunction

    function automatic logic exact_cout(input logic x, input logic y, input logic cin);
        return (x & y) | (x & cin) | (y & cin);
    endfunction

endpackage

// File: rtl/approx_ripple_adder.sv
// ----------------------------------------------------------------------------
// approx_ripple_adder
// N-bit ripple-carry adder whose low APPROX_BITS columns switch to the
// approximate cell when mode=1. Carry-out of the top column is discarded.
// Ports:
//   x, y  in  N  addends
//   mode  in  1  1 = low columns approximate, 0 = fully exact
//   sum   out N  x + y (approximate or exact), truncated to N bits
// ----------------------------------------------------------------------------
module approx_ripple_adder
    import approx_mult_pkg::*;
#(
    parameter int N           = 16,
    parameter int APPROX_BITS = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         mode,
    output logic [N-1:0] sum
);

    // Static per-column flag: which columns are built with the approximate cell.
    function automatic logic [N-1:0] approx_mask();
        logic [N-1:0] m;
        m = '0;
        for (int j = 0; j < N; j++) begin
            m[j] = (j < APPROX_BITS);
        end
        return m;
    endfunction

    localparam logic [N-1:0] APPROX_COLS = approx_mask();

    // carry[j] is the carry into column j; column 0 has no carry-in.
    logic [N-1:0] carry;
    assign carry[0] = 1'b0;

    for (genvar j = 0; j < N; j++) begin : g_col
        logic use_approx;
        logic col_cout;

        assign use_approx = mode & APPROX_COLS[j];
        assign sum[j]     = use_approx ? approx_sum(x[j], y[j])
                                       : exact_sum(x[j], y[j], carry[j]);
        assign col_cout   = use_approx ? approx_cout(x[j], y[j])
                                       : exact_cout(x[j], y[j], carry[j]);

        // Top column's carry-out has nowhere to go; only ripple below it.
        if (j < N - 1) begin : g_ripple
            assign carry[j+1] = col_cout;
        end
    end

endmodule

// File: rtl/approx_seq_multiplier.sv
// ----------------------------------------------------------------------------
// approx_seq_multiplier
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, with
// an accumulator adder whose low APPROX_BITS columns may run approximate.
// The accumulator loads only on cycles whose multiplier bit is 1, and the
// iteration stops as soon as the remaining multiplier bits are all zero.
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   in_valid/in_ready  operand handshake (accepted in IDLE only)
//   a, b             multiplicand / multiplier (unsigned, WIDTH bits)
//   approx_en        approximate mode, sampled with the operands
//   out_valid/out_ready product handshake (product held until taken)
//   product          registered 2*WIDTH-bit result
//   acc_en           accumulator load enable, exported for power accounting
// ----------------------------------------------------------------------------
module approx_seq_multiplier
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 acc_en
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state, state_next;
    logic [PW-1:0]     a_sh;     // multiplicand pre-shifted to the current bit
    logic [WIDTH-1:0]  b_rem;    // unprocessed multiplier bits, bit 0 = current
    logic              mode;
    logic [CNT_W-1:0]  idx;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_sum;
    logic              accept;
    logic              last_bit;

    assign accept = (state == IDLE) && in_valid;

    // Finished after this cycle if it is the top bit or nothing set remains above it.
    assign last_bit = (idx == CNT_W'(WIDTH - 1)) || (b_rem[WIDTH-1:1] == '0);

    approx_ripple_adder #(
        .N           (PW),
        .APPROX_BITS (APPROX_BITS)
    ) u_adder (
        .x    (acc),
        .y    (a_sh),
        .mode (mode),
        .sum  (acc_sum)
    );

    // ---------------- state register ----------------
    // NOTE: sequential state is updated with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment first guarantees every path drives
    // state_next, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // ---------------- outputs (state decode only) ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        acc_en    = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    acc_en    = b_rem[0];
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // NOTE: all datapath registers are reset so an aborted operation leaves
    // no residue and product reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_rem <= '0;
            mode  <= 1'b0;
            idx   <= '0;
            acc   <= '0;
        end else if (accept) begin
            a_sh  <= {{WIDTH{1'b0}}, a};
            b_rem <= b;
            mode  <= approx_en;
            idx   <= '0;
            acc   <= '0;
        end else if (state == CALC) begin
            if (acc_en) begin
                acc <= acc_sum;
            end
            a_sh  <= a_sh << 1;
            b_rem <= b_rem >> 1;
            idx   <= idx + 1'b1;
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_approx_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_approx_seq_multiplier
// Self-checking bench: two DUTs share stimulus, one with APPROX_BITS=4 and
// one fully exact (APPROX_BITS=0). Expected products come from an arithmetic
// reference of the approximate sum (OR'd low field, AND carry into the exact
// high field) accumulated over the set bits of b.
// ----------------------------------------------------------------------------
module tb_approx_seq_multiplier;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;
    localparam int K     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready, in_ready0;
    logic [WIDTH-1:0]  a, b;
    logic              approx_en;
    logic              out_valid, out_valid0;
    logic              out_ready;
    logic [PW-1:0]     product, product0;
    logic              acc_en, acc_en0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_seq_multiplier #(.WIDTH(WIDTH), .APPROX_BITS(K)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .acc_en(acc_en)
    );

    approx_seq_multiplier #(.WIDTH(WIDTH), .APPROX_BITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid0),
        .out_ready(out_ready), .product(product0), .acc_en(acc_en0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Approximate add: low K bits are x|y, carry into bit K is x&y at bit K-1,
    // upper field is an ordinary sum; result truncated to PW bits.
    function automatic int unsigned ref_add(input int unsigned x, input int unsigned y,
                                            input bit mode, input int k);
        int unsigned lo_mask, lo, c, hi;
        if (!mode || k == 0) return (x + y) & ((1 << PW) - 1);
        lo_mask = (1 << k) - 1;
        lo      = (x | y) & lo_mask;
        c       = ((x & y) >> (k - 1)) & 1;
        hi      = ((x >> k) + (y >> k) + c) << k;
        return (hi | lo) & ((1 << PW) - 1);
    endfunction

    function automatic int unsigned ref_mult(input int unsigned av, input int unsigned bv,
                                             input bit mode);
        int unsigned p = 0;
        for (int i = 0; i < WIDTH; i++)
            if (bv[i]) p = ref_add(p, av << i, mode, K);
        return p;
    endfunction

    // One transaction. exp_prod < 0 means "use the reference model".
    // abort_after > 0 pulses reset after that many CALC cycles.
    task automatic run_op(input int av, input int bv, input bit mode, input int exp_prod,
                          input int hold, input int abort_after);
        int unsigned exp_p;
        int          exp_cycles;
        int          calc;
        exp_p = (exp_prod >= 0) ? exp_prod : ref_mult(av, bv, mode);
        exp_cycles = 1;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) exp_cycles = i + 1;

        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; a = av[WIDTH-1:0]; b = bv[WIDTH-1:0]; approx_en = mode;
        @(negedge clk);
        // Scramble inputs: they must be ignored while busy.
        in_valid = 1'b1; a = $urandom; b = $urandom; approx_en = ~mode;

        calc = 0;
        while (!out_valid && calc < WIDTH + 2) begin
            if (abort_after > 0 && calc == abort_after) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort_in_ready", in_ready, 1);
                check("abort_out_valid", out_valid, 0);
                check("abort_acc_en", acc_en, 0);
                check("abort_product", product, 0);
                in_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("abort_no_output", out_valid, 0);
                return;
            end
            check("acc_en_calc", acc_en, bv[calc]);
            check("in_ready_busy", in_ready, 0);
            calc++;
            @(negedge clk);
        end
        check("calc_cycles", calc, exp_cycles);
        check("out_valid", out_valid, 1);
        check("product", product, exp_p);
        check("out_valid_exact", out_valid0, 1);
        check("product_exact", product0, av * bv);
        check("acc_en_done", acc_en, 0);

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; in_valid = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_product", product, exp_p);
            check("bp_in_ready", in_ready, 0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_in_ready_exact", in_ready0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; approx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_en", acc_en, 0);
        check("rst_product", product, 0);
        rst_n = 1'b1;

        run_op(13, 11, 1'b0, 143, 0, 0);
        run_op(13, 11, 1'b1, 159, 0, 0);
        run_op(3, 3, 1'b1, 7, 0, 0);
        run_op(3, 3, 1'b0, 9, 0, 0);
        run_op(255, 255, 1'b0, 65025, 0, 0);
        run_op(77, 0, 1'b1, 0, 0, 0);
        run_op(13, 11, 1'b1, 159, 5, 0);
        run_op(200, 100, 1'b0, -1, 0, 3);
        run_op(5, 6, 1'b0, 30, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int av, bv;
            av = $urandom_range(0, 255);
            bv = (n % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            run_op(av, bv, 1'($urandom_range(0, 1)), -1, $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
